uart_tx_unit: RTL and testbench
===============================

Name: uart_tx_unit

Overview:
Transmit side of the MiniUart. It takes a parallel byte from the CPU bus interface and shifts it out serially on TxD as: start bit, data bits LSB first, optional parity, one stop bit. Bit timing comes from the same oversampling enable tick that drives the receive unit, so one bit lasts OVERSAMPLE ticks. A one-entry holding register in front of the shift register allows back-to-back frames with no idle gap.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 8, en_tx ticks per bit period (2..16)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 1 selects odd parity, 0 selects even parity; ignored when PARITY_EN=0

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
en_tx  input  1  oversample tick, one clk wide, OVERSAMPLE ticks per bit
d_in  input  DATA_BITS  byte to transmit; sampled when load is accepted
load  input  1  write strobe from bus decode; one clk wide
txd  output  1  serial line, idle high, registered
ts  output  1  transmit status: 1 = holding register empty, can accept load
busy  output  1  1 while a frame is on the line (FSM not IDLE)

Behaviour:
- Reset (rst=0, asynchronous): txd=1, ts=1, busy=0, FSM=IDLE, holding register and shift register cleared, bit and tick counters cleared. Reset mid-frame aborts the frame; txd returns to 1 immediately.
- Load: accepted at a clk edge iff load=1 and ts=1. The holding register takes d_in and ts goes to 0 at that edge. load with ts=0 is ignored; the byte is dropped and the stored byte is unchanged.
- Acceptance uses registered ts only. A load in the same cycle that the holding register transfers out is ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP. FSM, counters and txd advance only on cycles with en_tx=1. When en_tx=0, all state holds.
- IDLE: txd=1. On en_tx with ts=0:
  - shift register takes the holding register; ts goes to 1.
  - txd goes to 0 and FSM enters START.
  - tick counter loads OVERSAMPLE-1 and bit counter loads DATA_BITS-1.
- Bit timing, common to START, DATA, PARITY, STOP: on each en_tx, if the tick counter is nonzero it decrements. If it is zero, the bit ends: the counter reloads OVERSAMPLE-1 and the state advances.
- START end: txd = shift[0]; go to DATA.
- DATA end:
  - If bit counter is nonzero: shift right, txd = next LSB, decrement bit counter.
  - Else if PARITY_EN: txd = XOR of all data bits, XOR PARITY_ODD; go to PARITY.
  - Otherwise: txd=1; go to STOP.
- PARITY end: txd=1; go to STOP.
- STOP end:
  - If ts=0: load the next byte exactly as in IDLE and go to START. No idle gap.
  - Otherwise txd=1 and go to IDLE.
- Frame length is (1 + DATA_BITS + PARITY_EN + 1) * OVERSAMPLE en_tx ticks. The start-bit falling edge appears on the first en_tx after ts=0 in IDLE.
- Parity is computed over the latched shift-register contents, never over live d_in.
- d_in changing after acceptance does not affect the frame in flight or the held byte.
- busy=1 from the START entry edge to the STOP exit edge into IDLE. busy stays 1 across chained frames.
- ts rises at the edge where the held byte moves into the shift register. A new load is accepted from the following cycle, while the current frame is still shifting.

Test Plan:
- Reset, no load, 200 en_tx ticks -> txd=1, ts=1, busy=0 throughout. Reset asserted mid-frame -> txd=1 the same cycle, ts=1, busy=0.
- Defaults, en_tx every clk, load 0x55 -> txd over 80 ticks is 0,1,0,1,0,1,0,1,0,1, each level held 8 ticks. Then idle high, busy falls after tick 80.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame = 88 ticks.
- Load 0xA3, then load 0x3C while frame 1 is in flight (ts=1) -> second start bit begins on the tick right after frame 1's stop bit. busy stays 1 for 160 ticks.
- Load 0x11 then 0x22 back to back, then 0x33 while ts=0 -> 0x33 dropped, line carries 0x11 then 0x22 only.
- en_tx asserted every 5th clk -> same waveform as the second scenario, stretched 5x in clk. No state change on cycles with en_tx=0.

Source files
------------

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: MiniUart transmitter, one-entry holding register feeding a shift register
//   clk    system clock
//   rst    asynchronous active-low reset
//   en_tx  oversample tick, OVERSAMPLE ticks per bit
//   d_in   byte to transmit, captured when a load is accepted
//   load   write strobe, accepted only while ts=1
//   txd    registered serial line, idle high
//   ts     1 = holding register empty
//   busy   1 while a frame is on the line
module uart_tx_unit #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_tx,
   input  logic [DATA_BITS-1:0] d_in,
   input  logic                 load,
   output logic                 txd,
   output logic                 ts,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
   localparam logic [3:0] TICK_MAX = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BIT_MAX  = 3'(DATA_BITS - 1);
   state_e               state_q, state_d;
   logic [3:0]           tick_q, tick_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
   logic                 ts_q, ts_d, txd_q, txd_d, par_q, par_d;
   logic                 xfer;
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      hold_d  = hold_q;
      ts_d    = ts_q;
      txd_d   = txd_q;
      par_d   = par_q;
      xfer    = 1'b0;
      if (load && ts_q) begin
         hold_d = d_in;
         ts_d   = 1'b0;
      end
      if (en_tx) begin
         if (state_q != IDLE && tick_q != 4'd0) tick_d = tick_q - 4'd1;
         else begin
            case (state_q)
               IDLE: begin
                  txd_d = 1'b1;
                  xfer  = !ts_q;
               end
               START: begin
                  tick_d  = TICK_MAX;
                  txd_d   = shift_q[0];
                  state_d = DATA;
               end
               DATA: begin
                  tick_d = TICK_MAX;
                  if (bit_q != 3'd0) begin
                     shift_d = shift_q >> 1;
                     txd_d   = shift_q[1];
                     bit_d   = bit_q - 3'd1;
                  end else if (PARITY_EN != 0) begin
                     txd_d   = par_q;
                     state_d = PARITY;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = STOP;
                  end
               end
               PARITY: begin
                  tick_d  = TICK_MAX;
                  txd_d   = 1'b1;
                  state_d = STOP;
               end
               STOP: begin
                  tick_d = TICK_MAX;
                  xfer   = !ts_q;
                  if (ts_q) begin
                     txd_d   = 1'b1;
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
      // Held byte moves to the shifter; parity is fixed here from the latched byte
      // because the shifter is consumed destructively during the data bits.
      if (xfer) begin
         shift_d = hold_q;
         par_d   = (^hold_q) ^ (PARITY_ODD != 0);
         ts_d    = 1'b1;
         txd_d   = 1'b0;
         tick_d  = TICK_MAX;
         bit_d   = BIT_MAX;
         state_d = START;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         hold_q  <= '0;
         ts_q    <= 1'b1;
         txd_q   <= 1'b1;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         hold_q  <= hold_d;
         ts_q    <= ts_d;
         txd_q   <= txd_d;
         par_q   <= par_d;
      end
   end
   assign txd  = txd_q;
   assign ts   = ts_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: checks three transmitter variants (no parity, even, odd) against a frame-level model
module tb_uart_tx_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_tx = 1'b0;
   logic       load = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [2:0] txd_w, ts_w, busy_w;
   int         passed = 0;
   int         total = 0;
   always #5 clk = ~clk;
   uart_tx_unit u0 (.clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in), .load(load),
                    .txd(txd_w[0]), .ts(ts_w[0]), .busy(busy_w[0]));
   uart_tx_unit #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in),
                    .load(load), .txd(txd_w[1]), .ts(ts_w[1]), .busy(busy_w[1]));
   uart_tx_unit #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in),
                    .load(load), .txd(txd_w[2]), .ts(ts_w[2]), .busy(busy_w[2]));
   // Frame-level model: a frame is a list of bit levels, each held 8 ticks.
   int         rem[3];
   logic [15:0] fb[3];
   logic [7:0] held[3];
   logic       ts_m[3], busy_m[3], txd_m[3];
   logic       lv[0:255], bz[0:255];
   typedef struct {
      logic [7:0] d;
      int         inst;
      int         len;
      logic       par;
   } vec_t;
   vec_t tv[7];
   function automatic int flen(int i);
      return (i > 0) ? 11 : 10;
   endfunction
   function automatic logic [15:0] build(logic [7:0] b, int i);
      logic [15:0] f;
      f = '0;
      f[8:1] = b;
      if (i > 0) begin
         f[9]  = (^b) ^ (i == 2);
         f[10] = 1'b1;
      end else f[9] = 1'b1;
      return f;
   endfunction
   task automatic chk(string nm, int i, int act, int exp);
      total++;
      if (act !== exp) $display("FAIL %s inst%0d actual=%0h required=%0h at %0t", nm, i, act, exp, $time);
      else passed++;
   endtask
   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         rem[i] = 0; held[i] = 8'h00; ts_m[i] = 1'b1; busy_m[i] = 1'b0; txd_m[i] = 1'b1;
      end
   endtask
   task automatic model_step(logic l, logic [7:0] d, logic e);
      for (int i = 0; i < 3; i++) begin
         automatic logic ts_old = ts_m[i];
         if (e) begin
            if (rem[i] == 0 && !ts_old) begin
               fb[i] = build(held[i], i);
               rem[i] = flen(i) * 8;
               busy_m[i] = 1'b1;
               ts_m[i] = 1'b1;
            end
            if (rem[i] > 0) begin
               txd_m[i] = fb[i][(flen(i) * 8 - rem[i]) / 8];
               rem[i]--;
            end else begin
               txd_m[i] = 1'b1;
               busy_m[i] = 1'b0;
            end
         end
         if (l && ts_old) begin
            held[i] = d;
            ts_m[i] = 1'b0;
         end
      end
   endtask
   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk("txd", i, int'(txd_w[i]), int'(txd_m[i]));
         chk("ts", i, int'(ts_w[i]), int'(ts_m[i]));
         chk("busy", i, int'(busy_w[i]), int'(busy_m[i]));
      end
   endtask
   task automatic step(logic l, logic [7:0] d, logic e);
      load = l; d_in = d; en_tx = e;
      @(posedge clk);
      model_step(l, d, e);
      #1;
      check_all();
   endtask
   task automatic areset();
      rst = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         chk("rst_txd", i, int'(txd_w[i]), 1);
         chk("rst_ts", i, int'(ts_w[i]), 1);
         chk("rst_busy", i, int'(busy_w[i]), 0);
      end
      #2;
      rst = 1'b1;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((busy_w != 3'b000 || ts_w != 3'b111) && n < 300) begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end
      chk("drain", 0, int'({busy_w, ts_w}), int'(6'b000111));
   endtask
   task automatic ticks(int from, int to);
      for (int n = from; n <= to; n++) begin
         step(1'b0, 8'h00, 1'b1);
         lv[n] = txd_w[0]; bz[n] = busy_w[0];
      end
   endtask
   function automatic logic [7:0] byte_at(int base);
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = lv[base + (1 + k) * 8 + 4];
      return b;
   endfunction
   initial begin
      int n, cnt;
      logic [7:0] b;
      tv[0] = '{8'h55, 0, 80, 1'b0};
      tv[1] = '{8'h07, 1, 88, 1'b1};
      tv[2] = '{8'h07, 2, 88, 1'b0};
      tv[3] = '{8'hA3, 1, 88, 1'b0};
      tv[4] = '{8'hFF, 2, 88, 1'b1};
      tv[5] = '{8'h80, 2, 88, 1'b0};
      tv[6] = '{8'h00, 0, 80, 1'b0};
      #1;
      areset();
      for (int k = 0; k < 200; k++) step(1'b0, 8'($urandom), 1'b1);
      for (int t = 0; t < 7; t++) begin
         step(1'b1, tv[t].d, 1'b0);
         n = 0;
         bz[0] = 1'b1;
         while (bz[0] && n < 200) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
            lv[n] = txd_w[tv[t].inst];
            bz[0] = busy_w[tv[t].inst];
         end
         chk("frame_len", tv[t].inst, n - 1, tv[t].len);
         chk("start_bit", tv[t].inst, int'(lv[4]), 0);
         for (int k = 0; k < 8; k++) b[k] = lv[(1 + k) * 8 + 4];
         chk("data", tv[t].inst, int'(b), int'(tv[t].d));
         if (tv[t].inst > 0) chk("parity", tv[t].inst, int'(lv[9 * 8 + 4]), int'(tv[t].par));
         chk("stop_bit", tv[t].inst, int'(lv[(flen(tv[t].inst) - 1) * 8 + 4]), 1);
         drain();
      end
      step(1'b1, 8'hA3, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      lv[1] = txd_w[0]; bz[1] = busy_w[0];
      step(1'b1, 8'h3C, 1'b1);
      lv[2] = txd_w[0]; bz[2] = busy_w[0];
      ticks(3, 161);
      cnt = 0;
      for (int k = 1; k <= 160; k++) cnt += int'(bz[k]);
      chk("chain_busy", 0, cnt, 160);
      chk("chain_gap", 0, int'({lv[80], lv[81]}), int'(2'b10));
      chk("chain_end", 0, int'(bz[161]), 0);
      chk("chain_b1", 0, int'(byte_at(0)), 8'hA3);
      chk("chain_b2", 0, int'(byte_at(80)), 8'h3C);
      drain();
      step(1'b1, 8'h11, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      lv[1] = txd_w[0]; bz[1] = busy_w[0];
      step(1'b1, 8'h22, 1'b1);
      lv[2] = txd_w[0]; bz[2] = busy_w[0];
      step(1'b1, 8'h33, 1'b1);
      lv[3] = txd_w[0]; bz[3] = busy_w[0];
      ticks(4, 181);
      chk("drop_b1", 0, int'(byte_at(0)), 8'h11);
      chk("drop_b2", 0, int'(byte_at(80)), 8'h22);
      cnt = 0;
      for (int k = 161; k <= 181; k++) cnt += int'(bz[k]) + int'(!lv[k]);
      chk("drop_idle", 0, cnt, 0);
      drain();
      step(1'b1, 8'h55, 1'b0);
      cnt = 0;
      for (int k = 1; k <= 420; k++) begin
         step(1'b0, 8'h00, k % 5 == 0);
         cnt += int'(busy_w[0]);
      end
      chk("slow_busy", 0, cnt, 400);
      drain();
      step(1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h5A, 1'b1);
      chk("pre_rst", 0, int'({txd_w[0], ts_w[0], busy_w[0]}), int'(3'b001));
      areset();
      for (int k = 0; k < 20; k++) step(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 3000; k++) step($urandom_range(19) == 0, 8'($urandom), 1'($urandom_range(1)));
      drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
